// File: rtl/ip_sound_mixer_pkg.sv
// rtl/ip_sound_mixer_pkg.sv - shared widths, FSM state type and constants for the sound mixer
//
// Contents:
//   SAMPLE_W      signed channel sample width
//   VOL_W         unsigned channel volume width
//   PROD_W        signed sample x volume product width
//   ACC_W         signed accumulator width (holds 4 x 32768 x 15 without overflow)
//   SILENCE       offset-binary midscale output
//   mixer_state_t IDLE / ACC / SAT
package ip_sound_mixer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 4;
  localparam int PROD_W   = SAMPLE_W + VOL_W + 1;
  localparam int ACC_W    = 23;

  localparam logic [SAMPLE_W-1:0] SILENCE = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } mixer_state_t;

endpackage

// File: rtl/ip_mixer_saturate.sv
// rtl/ip_mixer_saturate.sv - shift, clamp and offset-binary conversion of the mix accumulator
//
// Ports:
//   acc_i    signed accumulator (ACC_W bits), full sum of scaled channels
//   level_o  unsigned offset-binary level (SAMPLE_W bits), 0x8000 = silence
//
// Purely combinational. The shift truncates toward minus infinity; clamping
// is the only nonlinearity.
module ip_mixer_saturate
  import ip_sound_mixer_pkg::*;
#(
  parameter int SHIFT = 3
) (
  input  logic signed [ACC_W-1:0]    acc_i,
  output logic        [SAMPLE_W-1:0] level_o
);

  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] LIM_LO = ACC_W'(-32768);

  logic signed [ACC_W-1:0]    shifted;
  logic        [SAMPLE_W-1:0] clamped;

  always_comb begin
    shifted = acc_i >>> SHIFT;
    if (shifted > LIM_HI) begin
      clamped = 16'h7FFF;
    end else if (shifted < LIM_LO) begin
      clamped = 16'h8000;
    end else begin
      clamped = shifted[SAMPLE_W-1:0];
    end
    // Two's complement to offset binary: flip the sign bit.
    level_o = {~clamped[SAMPLE_W-1], clamped[SAMPLE_W-2:0]};
  end

endmodule

// File: rtl/ip_sound_mixer.sv
// rtl/ip_sound_mixer.sv - time-multiplexed 4-channel volume-scaled audio mixer feeding the PWM DAC
//
// Ports:
//   clk             system clock
//   n_reset         asynchronous active-low reset
//   enable          single-cycle sample strobe (ignored while busy)
//   channel_sample  four signed 16-bit samples, channel n at [16n+15:16n]
//   channel_volume  four unsigned 4-bit volumes, channel n at [4n+3:4n]
//   signal_level    registered offset-binary mix, held between updates
//   level_valid     one-cycle pulse when signal_level updates
//   busy            high while a mix is in progress (ACC and SAT)
module ip_sound_mixer
  import ip_sound_mixer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SHIFT    = 3
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         enable,
  input  logic [CHANNELS*SAMPLE_W-1:0] channel_sample,
  input  logic [CHANNELS*VOL_W-1:0]    channel_volume,
  output logic [SAMPLE_W-1:0]          signal_level,
  output logic                         level_valid,
  output logic                         busy
);

  localparam int CH_W = $clog2(CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  mixer_state_t                 state_q;
  logic [CH_W-1:0]              ch_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic [CHANNELS*SAMPLE_W-1:0] sample_q;
  logic [CHANNELS*VOL_W-1:0]    volume_q;
  logic [SAMPLE_W-1:0]          level_q;
  logic                         level_valid_q;

  logic signed [SAMPLE_W-1:0] sample_sel;
  logic [VOL_W-1:0]           volume_sel;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_d;
  logic [SAMPLE_W-1:0]        sat_level;

  // One multiply-accumulate per clock on the channel selected by ch_q.
  always_comb begin
    sample_sel = sample_q[SAMPLE_W*ch_q +: SAMPLE_W];
    volume_sel = volume_q[VOL_W*ch_q +: VOL_W];
    // Zero-extended volume keeps the multiply signed without treating 8..15 as negative.
    prod       = sample_sel * $signed({1'b0, volume_sel});
    acc_d      = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  ip_mixer_saturate #(
    .SHIFT (SHIFT)
  ) u_saturate (
    .acc_i   (acc_q),
    .level_o (sat_level)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      acc_q         <= '0;
      sample_q      <= '0;
      volume_q      <= '0;
      level_q       <= SILENCE;
      level_valid_q <= 1'b0;
    end else begin
      level_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            sample_q <= channel_sample;
            volume_q <= channel_volume;
            acc_q    <= '0;
            ch_q     <= '0;
            state_q  <= ACC;
          end
        end
        ACC: begin
          acc_q <= acc_d;
          ch_q  <= ch_q + CH_W'(1);
          if (ch_q == LAST_CH) begin
            state_q <= SAT;
          end
        end
        SAT: begin
          level_q       <= sat_level;
          level_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign signal_level = level_q;
  assign level_valid  = level_valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/ip_sound_mixer.md
# ip_sound_mixer

Time-multiplexed 4-channel audio mixer that feeds the PWM DAC stage. It snapshots four signed 16-bit channel samples on each sample strobe and scales each by a 4-bit volume. It accumulates the scaled samples over four clocks, saturates the sum, and converts it to unsigned offset-binary. The result drives the `signal_level[15:0]` input of the PWM stage. Both blocks share the same `clk` (21.477 MHz) and the same 1-in-8 `enable` strobe.

## Interface
- `CHANNELS`, default 4: number of mixed channels. RTL is written for 4; other values are unsupported.
- `SHIFT`, default 3: arithmetic right shift applied after accumulation. Gain per channel is volume/8.
- `n_reset`: input, 1 bit. Reset, asynchronous, active-low.
- `clk`: input, 1 bit. Clock.
- `enable`: input, 1 bit. Single-cycle sample strobe, nominally one pulse every 8 clocks.
- `channel_sample`: input, 64 bits. Four signed two's-complement samples; channel n occupies bits [16n+15:16n].
- `channel_volume`: input, 16 bits. Four unsigned volumes 0..15; channel n occupies bits [4n+3:4n].
- `signal_level`: output, 16 bits. Unsigned mixed level, 0x8000 = silence. Connects to the PWM stage.
- `level_valid`: output, 1 bit. One-cycle pulse in the clock where `signal_level` takes a new value.
- `busy`: output, 1 bit. High while a mix is in progress.

## Operation
- FSM has three states: IDLE, ACC, SAT.
- IDLE:
  - On `enable`=1, capture all of `channel_sample` and `channel_volume` into snapshot registers.
  - Clear the accumulator and set channel counter `ch` to 0.
  - Go to ACC.
- ACC, once per clock:
  - Form product = signed(sample[ch]) × {1'b0, volume[ch]}. The product is 21-bit signed.
  - Sign-extend the product to 23 bits and add it to the accumulator.
  - Increment `ch`. After `ch`=3 has been added, go to SAT.
- SAT:
  - Take accumulator >>> SHIFT (arithmetic shift, result held as 20-bit signed).
  - Clamp to [-32768, +32767].
  - Invert the MSB to produce offset-binary.
  - Register the result into `signal_level`, pulse `level_valid`, and return to IDLE.
- Width rules:
  - Maximum magnitude is 4 × 32768 × 15 = 1 966 080, which fits in 23-bit signed. The accumulator cannot overflow.
  - Saturation is the only nonlinearity. There is no rounding; the shift truncates toward −∞.
- `enable` while `busy`=1 is ignored. There is no queueing and no flag.
- Inputs may change freely after capture. Only snapshot values are used for the current mix.
- `busy` is high in ACC and SAT.

## Timing
- Reset values: `signal_level`=0x8000, `level_valid`=0, `busy`=0. FSM goes to IDLE, `ch`=0, accumulator=0, snapshots=0.
- Cycle sequence, with E = the rising edge that samples `enable`=1 in IDLE:
  - E+1 through E+4: ACC for channels 0, 1, 2, 3.
  - E+5: SAT. `signal_level` and `level_valid` change at this edge.
- Latency from enable to output is 5 clocks.
- Total occupancy is 6 states, so the block is back in IDLE before the next nominal strobe at E+8.
- Minimum strobe spacing the block accepts is 6 clocks. Any `enable` at E+1 through E+5 is dropped.
- `signal_level` holds its value between updates. The PWM stage samples it on its own `enable`; a one-period lag is acceptable.
- Asserting reset mid-mix aborts immediately:
  - All outputs return to their reset values, so the output returns to midscale.
  - The next mix starts only on a fresh `enable` after reset is released.

## Structure
- Package `ip_sound_mixer_pkg` holds:
  - `SAMPLE_W`=16, `VOL_W`=4, `ACC_W`=23.
  - The FSM state enum `mixer_state_t` {IDLE, ACC, SAT}.
  - The constant `SILENCE`=16'h8000.
- One sub-module: `ip_mixer_saturate`. It is combinational: a 23-bit accumulator input and a 16-bit offset-binary output, covering the shift, clamp and MSB flip.
- Everything else, including snapshots, FSM, MAC and output register, lives in `ip_sound_mixer`.

## Test plan
1. **Reset.** Hold `n_reset`=0 with arbitrary inputs. Required: `signal_level`=0x8000, `busy`=0, `level_valid`=0.
2. **Single channel.** Set ch0=0x1000, vol0=8, all other volumes 0, then pulse `enable`. Required: `signal_level`=0x9000, with `level_valid` exactly 5 clocks after the strobe.
3. **Mixed signs.** Set ch0=+1000/vol 8, ch1=−1000/vol 8, ch2=0x0010/vol 15, ch3=−1/vol 1. Sum is 240−1=239, and 239>>>3=29. Required: `signal_level`=0x801D.
4. **Saturation.**
   - All samples 0x7FFF, all volumes 15: required 0xFFFF.
   - All samples 0x8000, all volumes 15: required 0x0000.
   - ch0=−1, vol0=1, others silent: −1>>>3=−1, required 0x7FFF.
5. **Busy and snapshot.**
   - Pulse `enable`, change `channel_sample` at E+1, and pulse `enable` again at E+3. Required: the output reflects the first snapshot only, and only one `level_valid` is produced.
   - Drive `enable` every 8 clocks for 1000 strobes alongside the PWM stage. Required: no dropped updates.
6. **Reset mid-mix.** Assert `n_reset` at E+2. Required: `signal_level`=0x8000 immediately, no `level_valid`, and a correct result after the next strobe.
